hdma_axi_scheduler: RTL and testbench
=====================================

Name: hdma_axi_scheduler

Overview:
- Sequences shared AXI4 DDR3 port between three burst requesters: video write FIFO 1, video write FIFO 2, display read FIFO.
- Sits between HDMA FIFO controller (level counts) and AXI burst engine (one burst per request).
- Drives the channel-select enables that steer AXI data to/from FIFOs.
- Arbitration order: urgent read, then round-robin writes, then normal read.

Parameters:
- RFIFO_DEPTH, 1024, read FIFO capacity in 128-bit beats.
- RD_LOW_WM, 256, read FIFO level below which a read is urgent.
- TIMEOUT_CYC, 4095, max cycles in BUSY before abort; 12-bit counter.

Ports:
- clk  in  1  AXI clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- ddr_init_done  in  1  DDR3 calibrated; scheduler idle while low.
- ddr3_read_valid  in  1  read path enabled.
- wr_opera_en_2  in  1  channel 2 write enabled.
- wr_bust_len  in  8  write burst length in beats.
- rd_bust_len  in  8  read burst length in beats.
- wfifo_rcount_1  in  11  beats available in write FIFO 1.
- wfifo_rcount_2  in  11  beats available in write FIFO 2.
- rfifo_wcount  in  11  beats held in read FIFO.
- req_ready  in  1  burst engine accepts request.
- burst_done  in  1  one-cycle pulse: write response or rlast beat accepted.
- req_valid  out  1  burst request to engine.
- req_type  out  1  0 write, 1 read.
- wr_opera_en_1  out  1  write data sourced from FIFO 1 (0: FIFO 2).
- rd_opera_en_1  out  1  read data steered to read FIFO.
- busy  out  1  state is not IDLE or ARB.
- err_timeout  out  1  sticky; set on BUSY timeout.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0; state IDLE; RR pointer = ch1; timeout counter 0.
  - Clock and reset are fixed: one clock, asynchronous active-low reset.
- States and transitions:
  - IDLE -> ARB when ddr_init_done = 1.
  - ARB -> REQ when any requester is eligible; otherwise stay in ARB.
  - REQ -> BUSY on req_ready.
  - BUSY -> ARB on burst_done, or on timeout.
- Eligibility, evaluated in ARB on registered inputs (11-bit compares, lengths zero-extended):
  - W1: wfifo_rcount_1 >= wr_bust_len, and wr_bust_len != 0.
  - W2: wr_opera_en_2 = 1, wfifo_rcount_2 >= wr_bust_len, and wr_bust_len != 0.
  - RU (urgent read): ddr3_read_valid = 1, rd_bust_len != 0, and rfifo_wcount < RD_LOW_WM.
  - RN (normal read): ddr3_read_valid = 1, rd_bust_len != 0, and rfifo_wcount + rd_bust_len <= RFIFO_DEPTH. Sum is computed at 12 bits, so it cannot wrap.
- Priority: RU > writes > RN.
  - Between W1 and W2, the RR pointer picks the favoured channel; if only one is eligible, it is granted.
  - The RR pointer flips to the other channel after every granted write.
  - Reads do not move the RR pointer.
- Grant registers (req_type, wr_opera_en_1, rd_opera_en_1):
  - Load on the ARB -> REQ edge.
  - Held constant through REQ and BUSY.
  - On a write grant, rd_opera_en_1 = 0.
  - On a read grant, wr_opera_en_1 keeps its previous value.
- REQ handshake:
  - req_valid = 1 from the first REQ cycle until the cycle req_ready is sampled high.
  - req_valid drops on the next edge.
  - req_type is stable while req_valid = 1.
- Latency:
  - Eligibility in ARB -> req_valid high 1 cycle later.
  - burst_done -> next req_valid no earlier than 2 cycles later (the ARB cycle plus the REQ entry).
- Stray pulses: burst_done outside BUSY is ignored; req_ready outside REQ is ignored.
- Timeout:
  - The counter clears on BUSY entry and increments each cycle in BUSY.
  - If it reaches TIMEOUT_CYC: err_timeout <= 1 (sticky until reset) and state -> ARB.
  - If burst_done arrives in the same cycle the count reaches TIMEOUT_CYC, burst_done wins and no error is flagged.
- ddr_init_done falls in any state: next state IDLE, req_valid <= 0, grants cleared, RR pointer kept.
- Eligibility inputs changing during REQ or BUSY do not affect the current grant.

Test Plan:
- Reset, ddr_init_done = 1, wr_bust_len = 16, wfifo_rcount_1 = 16, all else 0 -> req_valid at cycle 2 after ARB, req_type = 0, wr_opera_en_1 = 1; req_ready pulse, burst_done 20 cycles later -> back to ARB, busy falls.
- W1 and W2 both at 64, wr_opera_en_2 = 1, engine acknowledges every burst -> grants alternate 1,2,1,2; wr_opera_en_1 toggles 1,0,1,0.
- rfifo_wcount = 100 (below RD_LOW_WM 256), rd_bust_len = 16, W1 eligible -> read granted first (req_type = 1, rd_opera_en_1 = 1); then with rfifo_wcount = 600, W1 granted ahead of RN.
- rfifo_wcount = 1010, rd_bust_len = 16, no writes eligible -> no request (1026 > 1024); rfifo_wcount = 1008 -> read issued.
- Grant, then withhold burst_done -> err_timeout rises after 4095 BUSY cycles and state returns to ARB; burst_done coincident with the final count -> err_timeout stays 0.
- Drop ddr_init_done mid-BUSY -> next cycle state IDLE, req_valid = 0, grants = 0; reassert with pending W1 -> normal grant resumes.

Source files
------------

// File: rtl/hdma_axi_scheduler.sv
// Schedules the shared AXI4 DDR3 port between two video write FIFOs and the display read FIFO,
// issuing one burst request at a time and steering data through the channel-select enables.
module hdma_axi_scheduler #(
    parameter int RFIFO_DEPTH = 1024,
    parameter int RD_LOW_WM   = 256,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ddr_init_done,
    input  logic        ddr3_read_valid,
    input  logic        wr_opera_en_2,
    input  logic [7:0]  wr_bust_len,
    input  logic [7:0]  rd_bust_len,
    input  logic [10:0] wfifo_rcount_1,
    input  logic [10:0] wfifo_rcount_2,
    input  logic [10:0] rfifo_wcount,
    input  logic        req_ready,
    input  logic        burst_done,
    output logic        req_valid,
    output logic        req_type,
    output logic        wr_opera_en_1,
    output logic        rd_opera_en_1,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [10:0] RD_LOW_WM_C   = 11'(RD_LOW_WM);
    localparam logic [11:0] RFIFO_DEPTH_C = 12'(RFIFO_DEPTH);
    localparam logic [11:0] TMO_LAST_C    = 12'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_REQ  = 2'd2,
        S_BUSY = 2'd3
    } state_e;

    state_e      state_q;
    logic        rd_valid_q;
    logic        wr_en2_q;
    logic [7:0]  wr_len_q;
    logic [7:0]  rd_len_q;
    logic [10:0] wcnt1_q;
    logic [10:0] wcnt2_q;
    logic [10:0] rcnt_q;
    logic        rr_ch2_q;
    logic [11:0] tmo_q;
    logic        req_valid_q;
    logic        req_type_q;
    logic        wr_en1_q;
    logic        rd_en1_q;
    logic        busy_q;
    logic        err_q;

    logic        elig_w1_s;
    logic        elig_w2_s;
    logic        elig_ru_s;
    logic        elig_rn_s;
    logic        any_s;
    logic        read_s;
    logic        pick_w1_s;
    logic [11:0] rn_sum_s;

    // Level/length snapshot: arbitration only ever looks at these registered copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            wr_en2_q   <= 1'b0;
            wr_len_q   <= 8'd0;
            rd_len_q   <= 8'd0;
            wcnt1_q    <= 11'd0;
            wcnt2_q    <= 11'd0;
            rcnt_q     <= 11'd0;
        end else begin
            rd_valid_q <= ddr3_read_valid;
            wr_en2_q   <= wr_opera_en_2;
            wr_len_q   <= wr_bust_len;
            rd_len_q   <= rd_bust_len;
            wcnt1_q    <= wfifo_rcount_1;
            wcnt2_q    <= wfifo_rcount_2;
            rcnt_q     <= rfifo_wcount;
        end
    end

    // Eligibility of each requester and the resulting grant choice
    always_comb begin
        rn_sum_s  = {1'b0, rcnt_q} + {4'b0000, rd_len_q};
        elig_w1_s = (wr_len_q != 8'd0) && (wcnt1_q >= {3'b000, wr_len_q});
        elig_w2_s = wr_en2_q && (wr_len_q != 8'd0) && (wcnt2_q >= {3'b000, wr_len_q});
        elig_ru_s = rd_valid_q && (rd_len_q != 8'd0) && (rcnt_q < RD_LOW_WM_C);
        elig_rn_s = rd_valid_q && (rd_len_q != 8'd0) && (rn_sum_s <= RFIFO_DEPTH_C);
        // With both writers ready the pointer decides; otherwise whichever is ready wins
        pick_w1_s = elig_w1_s && (!elig_w2_s || !rr_ch2_q);
        read_s    = elig_ru_s || (elig_rn_s && !elig_w1_s && !elig_w2_s);
        any_s     = elig_ru_s || elig_w1_s || elig_w2_s || elig_rn_s;
    end

    // Scheduler FSM with registered request, grant and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ch2_q    <= 1'b0;
            tmo_q       <= 12'd0;
            req_valid_q <= 1'b0;
            req_type_q  <= 1'b0;
            wr_en1_q    <= 1'b0;
            rd_en1_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else if (!ddr_init_done) begin
            state_q     <= S_IDLE;
            tmo_q       <= 12'd0;
            req_valid_q <= 1'b0;
            req_type_q  <= 1'b0;
            wr_en1_q    <= 1'b0;
            rd_en1_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_ARB;
                end
                S_ARB: begin
                    if (any_s) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        req_type_q  <= read_s;
                        rd_en1_q    <= read_s;
                        if (!read_s) begin
                            wr_en1_q <= pick_w1_s;
                            rr_ch2_q <= pick_w1_s;
                        end
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        state_q     <= S_BUSY;
                        req_valid_q <= 1'b0;
                        tmo_q       <= 12'd0;
                    end
                end
                S_BUSY: begin
                    tmo_q <= tmo_q + 12'd1;
                    // A completion in the final counted cycle still counts as a clean finish
                    if (burst_done) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b0;
                    end else if (tmo_q == TMO_LAST_C) begin
                        state_q <= S_ARB;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid     = req_valid_q;
    assign req_type      = req_type_q;
    assign wr_opera_en_1 = wr_en1_q;
    assign rd_opera_en_1 = rd_en1_q;
    assign busy          = busy_q;
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_hdma_axi_scheduler.sv
// Directed bench for hdma_axi_scheduler: arbitration order, round-robin, read watermarks,
// timeout behaviour and DDR-init drop, with hand-computed expectations.
module tb_hdma_axi_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ddr_init_done;
    logic        ddr3_read_valid;
    logic        wr_opera_en_2;
    logic [7:0]  wr_bust_len;
    logic [7:0]  rd_bust_len;
    logic [10:0] wfifo_rcount_1;
    logic [10:0] wfifo_rcount_2;
    logic [10:0] rfifo_wcount;
    logic        req_ready;
    logic        burst_done;
    logic        req_valid;
    logic        req_type;
    logic        wr_opera_en_1;
    logic        rd_opera_en_1;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    hdma_axi_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ddr_init_done   (ddr_init_done),
        .ddr3_read_valid (ddr3_read_valid),
        .wr_opera_en_2   (wr_opera_en_2),
        .wr_bust_len     (wr_bust_len),
        .rd_bust_len     (rd_bust_len),
        .wfifo_rcount_1  (wfifo_rcount_1),
        .wfifo_rcount_2  (wfifo_rcount_2),
        .rfifo_wcount    (rfifo_wcount),
        .req_ready       (req_ready),
        .burst_done      (burst_done),
        .req_valid       (req_valid),
        .req_type        (req_type),
        .wr_opera_en_1   (wr_opera_en_1),
        .rd_opera_en_1   (rd_opera_en_1),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        ddr_init_done   = 1'b0;
        ddr3_read_valid = 1'b0;
        wr_opera_en_2   = 1'b0;
        wr_bust_len     = 8'd0;
        rd_bust_len     = 8'd0;
        wfifo_rcount_1  = 11'd0;
        wfifo_rcount_2  = 11'd0;
        rfifo_wcount    = 11'd0;
        req_ready       = 1'b0;
        burst_done      = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for a request, check its grant fields, then accept it
    task automatic issue(input string tag, input logic t, input logic w1, input logic r1);
        int n;
        n = 0;
        while (req_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {11'd0, req_valid}, 12'd1);
        chk({tag, "_type"}, {11'd0, req_type}, {11'd0, t});
        chk({tag, "_wr1"}, {11'd0, wr_opera_en_1}, {11'd0, w1});
        chk({tag, "_rd1"}, {11'd0, rd_opera_en_1}, {11'd0, r1});
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        chk({tag, "_acc_valid"}, {11'd0, req_valid}, 12'd0);
        chk({tag, "_acc_busy"}, {11'd0, busy}, 12'd1);
    endtask

    task automatic finish_burst(input string tag);
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        chk({tag, "_done_busy"}, {11'd0, busy}, 12'd0);
    endtask

    initial begin
        apply_reset();
        chk("rst_valid", {11'd0, req_valid}, 12'd0);
        chk("rst_type", {11'd0, req_type}, 12'd0);
        chk("rst_wr1", {11'd0, wr_opera_en_1}, 12'd0);
        chk("rst_rd1", {11'd0, rd_opera_en_1}, 12'd0);
        chk("rst_busy", {11'd0, busy}, 12'd0);
        chk("rst_err", {11'd0, err_timeout}, 12'd0);

        // Single W1 burst: IDLE->ARB, then REQ one cycle later
        ddr_init_done  = 1'b1;
        wr_bust_len    = 8'd16;
        wfifo_rcount_1 = 11'd16;
        tick();
        chk("t1_arb_valid", {11'd0, req_valid}, 12'd0);
        tick();
        chk("t1_lat_valid", {11'd0, req_valid}, 12'd1);
        issue("t1", 1'b0, 1'b1, 1'b0);
        wfifo_rcount_1 = 11'd0;
        repeat (19) tick();
        chk("t1_still_busy", {11'd0, busy}, 12'd1);
        finish_burst("t1");
        tick();
        chk("t1_idle_valid", {11'd0, req_valid}, 12'd0);

        // Round-robin between both write channels
        apply_reset();
        ddr_init_done  = 1'b1;
        wr_bust_len    = 8'd16;
        wfifo_rcount_1 = 11'd64;
        wfifo_rcount_2 = 11'd64;
        wr_opera_en_2  = 1'b1;
        issue("rr_a", 1'b0, 1'b1, 1'b0);
        finish_burst("rr_a");
        issue("rr_b", 1'b0, 1'b0, 1'b0);
        finish_burst("rr_b");
        issue("rr_c", 1'b0, 1'b1, 1'b0);
        finish_burst("rr_c");
        issue("rr_d", 1'b0, 1'b0, 1'b0);
        wr_opera_en_2   = 1'b0;
        wfifo_rcount_2  = 11'd0;
        ddr3_read_valid = 1'b1;
        rd_bust_len     = 8'd16;
        rfifo_wcount    = 11'd100;
        finish_burst("rr_d");

        // Urgent read beats W1; read keeps the previous write steering
        issue("ru", 1'b1, 1'b0, 1'b1);
        rfifo_wcount = 11'd600;
        finish_burst("ru");
        issue("w1_over_rn", 1'b0, 1'b1, 1'b0);
        wfifo_rcount_1 = 11'd0;
        rfifo_wcount   = 11'd1009;
        finish_burst("w1_over_rn");

        // 1009 + 16 = 1025 exceeds depth: nothing may be requested
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rn_full_valid", {11'd0, req_valid}, 12'd0);
        end
        burst_done = 1'b1;
        req_ready  = 1'b1;
        tick();
        burst_done = 1'b0;
        req_ready  = 1'b0;
        chk("stray_busy", {11'd0, busy}, 12'd0);
        chk("stray_valid", {11'd0, req_valid}, 12'd0);
        rfifo_wcount = 11'd1008;
        issue("rn_edge", 1'b1, 1'b1, 1'b1);

        // Timeout: BUSY lasts 4095 cycles before the abort
        ddr3_read_valid = 1'b0;
        repeat (4094) tick();
        chk("tmo_pre_busy", {11'd0, busy}, 12'd1);
        chk("tmo_pre_err", {11'd0, err_timeout}, 12'd0);
        tick();
        chk("tmo_err", {11'd0, err_timeout}, 12'd1);
        chk("tmo_busy", {11'd0, busy}, 12'd0);

        // burst_done on the final count wins over the timeout
        apply_reset();
        ddr_init_done   = 1'b1;
        ddr3_read_valid = 1'b1;
        rd_bust_len     = 8'd16;
        rfifo_wcount    = 11'd100;
        issue("tmo2", 1'b1, 1'b0, 1'b1);
        ddr3_read_valid = 1'b0;
        repeat (4094) tick();
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
        chk("tmo2_err", {11'd0, err_timeout}, 12'd0);
        chk("tmo2_busy", {11'd0, busy}, 12'd0);

        // DDR init drop mid-BUSY clears grants; reassert resumes
        wr_bust_len    = 8'd16;
        wfifo_rcount_1 = 11'd16;
        issue("drop", 1'b0, 1'b1, 1'b0);
        ddr_init_done = 1'b0;
        tick();
        chk("drop_busy", {11'd0, busy}, 12'd0);
        chk("drop_valid", {11'd0, req_valid}, 12'd0);
        chk("drop_type", {11'd0, req_type}, 12'd0);
        chk("drop_wr1", {11'd0, wr_opera_en_1}, 12'd0);
        chk("drop_rd1", {11'd0, rd_opera_en_1}, 12'd0);
        ddr_init_done = 1'b1;
        issue("resume", 1'b0, 1'b1, 1'b0);
        finish_burst("resume");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
